// File: rtl/amux_pkg.sv
// Shared types and constants for the analog mux enable sequencer.
package amux_pkg;

    localparam int N_CH = 8;
    localparam int CH_W = $clog2(N_CH);

    typedef enum logic [2:0] {
        IDLE,
        BREAK,
        SETTLE,
        DWELL,
        HOLD
    } state_t;

    function automatic logic [N_CH-1:0] onehot(input logic [CH_W-1:0] idx);
        logic [N_CH-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/amux_next_ch.sv
// Finds the next set bit of a channel mask strictly above cur_i, wrapping modulo N_CH.
module amux_next_ch
    import amux_pkg::*;
(
    input  logic [N_CH-1:0] mask_i,
    input  logic [CH_W-1:0] cur_i,
    output logic [CH_W-1:0] nxt_o,
    output logic            none_o
);

    logic found;

    // The search reaches cur_i itself last, so a single-bit mask returns cur_i.
    always_comb begin
        nxt_o = '0;
        found = 1'b0;
        for (int unsigned i = 1; i <= N_CH; i++) begin
            int unsigned k;
            k = (32'(cur_i) + i) % N_CH;
            if (!found && mask_i[k]) begin
                nxt_o = CH_W'(k);
                found = 1'b1;
            end
        end
    end

    assign none_o = ~found;

endmodule

// File: rtl/amux_scan_ctrl.sv
// Break-before-make sequencer for the 8-channel analog mux enables,
// supporting a held manual channel or a round-robin scan with dwell.
module amux_scan_ctrl
    import amux_pkg::*;
#(
    parameter int DWELL_W    = 16,
    parameter int DEAD_CYC   = 4,
    parameter int SETTLE_CYC = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               mode,
    input  logic [CH_W-1:0]    man_ch,
    input  logic               man_load,
    input  logic [N_CH-1:0]    scan_mask,
    input  logic [DWELL_W-1:0] dwell,
    output logic [N_CH-1:0]    amux_en,
    output logic [N_CH-1:0]    amux_en_neg,
    output logic [CH_W-1:0]    ch_idx,
    output logic               ch_valid,
    output logic               ch_strobe,
    output logic               busy
);

    localparam int CNT_MAX = (DEAD_CYC > SETTLE_CYC) ? DEAD_CYC : SETTLE_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] DEAD_LAST   = CNT_W'(DEAD_CYC - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'((SETTLE_CYC > 0) ? SETTLE_CYC - 1 : 0);

    state_t             state_q, state_d;
    logic [CH_W-1:0]    tgt_q, tgt_d;
    logic               scan_q, scan_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [DWELL_W-1:0] dw_cnt_q, dw_cnt_d;
    logic [N_CH-1:0]    en_q, en_d;
    logic [N_CH-1:0]    en_neg_q;
    logic [CH_W-1:0]    idx_q, idx_d;
    logic               valid_q, valid_d;
    logic               strobe_q, strobe_d;
    logic               busy_q;

    logic [CH_W-1:0]    search_from;
    logic [CH_W-1:0]    nxt_ch;
    logic               nxt_none;
    logic [DWELL_W-1:0] dwell_eff;
    logic               go_run;

    // From IDLE, searching above the top channel yields the lowest set bit.
    assign search_from = (state_q == IDLE) ? CH_W'(N_CH - 1) : idx_q;
    assign dwell_eff   = (dwell == '0) ? DWELL_W'(1) : dwell;

    amux_next_ch u_next_ch (
        .mask_i (scan_mask),
        .cur_i  (search_from),
        .nxt_o  (nxt_ch),
        .none_o (nxt_none)
    );

    always_comb begin
        state_d  = state_q;
        tgt_d    = tgt_q;
        scan_d   = scan_q;
        cnt_d    = cnt_q;
        dw_cnt_d = dw_cnt_q;
        en_d     = en_q;
        idx_d    = idx_q;
        valid_d  = valid_q;
        strobe_d = 1'b0;
        go_run   = 1'b0;

        // A mode flip mid-operation is handled exactly like dropping en.
        if (!en || (state_q != IDLE && mode != scan_q)) begin
            state_d = IDLE;
            en_d    = '0;
            valid_d = 1'b0;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    en_d    = '0;
                    valid_d = 1'b0;
                    if (!mode && man_load) begin
                        tgt_d   = man_ch;
                        scan_d  = 1'b0;
                        cnt_d   = '0;
                        state_d = BREAK;
                    end else if (mode && !nxt_none) begin
                        tgt_d   = nxt_ch;
                        scan_d  = 1'b1;
                        cnt_d   = '0;
                        state_d = BREAK;
                    end
                end
                BREAK: begin
                    if (!scan_q && man_load) begin
                        tgt_d = man_ch;
                        cnt_d = '0;
                    end else if (cnt_q == DEAD_LAST) begin
                        en_d  = onehot(tgt_q);
                        idx_d = tgt_q;
                        cnt_d = '0;
                        if (SETTLE_CYC == 0) go_run = 1'b1;
                        else                 state_d = SETTLE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                SETTLE: begin
                    if (!scan_q && man_load) begin
                        tgt_d   = man_ch;
                        cnt_d   = '0;
                        en_d    = '0;
                        state_d = BREAK;
                    end else if (cnt_q == SETTLE_LAST) begin
                        go_run = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                DWELL: begin
                    // Strobe is registered, so it is raised on the edge entering the last cycle.
                    if (dw_cnt_q > DWELL_W'(1)) begin
                        dw_cnt_d = dw_cnt_q - DWELL_W'(1);
                        strobe_d = (dw_cnt_q == DWELL_W'(2));
                    end else if (nxt_none) begin
                        state_d = IDLE;
                        en_d    = '0;
                        valid_d = 1'b0;
                    end else if (nxt_ch == idx_q) begin
                        dw_cnt_d = dwell_eff;
                        strobe_d = (dwell_eff == DWELL_W'(1));
                    end else begin
                        tgt_d   = nxt_ch;
                        cnt_d   = '0;
                        en_d    = '0;
                        valid_d = 1'b0;
                        state_d = BREAK;
                    end
                end
                HOLD: begin
                    if (man_load && man_ch != idx_q) begin
                        tgt_d   = man_ch;
                        cnt_d   = '0;
                        en_d    = '0;
                        valid_d = 1'b0;
                        state_d = BREAK;
                    end
                end
                default: begin
                    state_d = IDLE;
                    en_d    = '0;
                    valid_d = 1'b0;
                end
            endcase

            if (go_run) begin
                valid_d = 1'b1;
                if (scan_q) begin
                    state_d  = DWELL;
                    dw_cnt_d = dwell_eff;
                    strobe_d = (dwell_eff == DWELL_W'(1));
                end else begin
                    state_d = HOLD;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            tgt_q    <= '0;
            scan_q   <= 1'b0;
            cnt_q    <= '0;
            dw_cnt_q <= '0;
            en_q     <= '0;
            en_neg_q <= '1;
            idx_q    <= '0;
            valid_q  <= 1'b0;
            strobe_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            tgt_q    <= tgt_d;
            scan_q   <= scan_d;
            cnt_q    <= cnt_d;
            dw_cnt_q <= dw_cnt_d;
            en_q     <= en_d;
            en_neg_q <= ~en_d;
            idx_q    <= idx_d;
            valid_q  <= valid_d;
            strobe_q <= strobe_d;
            busy_q   <= (state_d != IDLE);
        end
    end

    assign amux_en     = en_q;
    assign amux_en_neg = en_neg_q;
    assign ch_idx      = idx_q;
    assign ch_valid    = valid_q;
    assign ch_strobe   = strobe_q;
    assign busy        = busy_q;

endmodule
